// File: rtl/line_memory.sv
// Line-granular backing memory with a fixed access latency.
// One request is in flight at a time: it is captured on acceptance and
// completes LATENCY cycles later. Its result is held until the cache
// acknowledges it with op_done.
module line_memory #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int LINE_SIZE     = 128,
  parameter int DEPTH_LINES   = 4096,
  parameter int LATENCY       = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     op,
  input  logic [ADDRESS_WIDTH-1:0] address,
  input  logic [LINE_SIZE-1:0]     data_in,
  input  logic                     op_done,
  output logic [LINE_SIZE-1:0]     data_out,
  output logic                     data_ready,
  output logic                     in_use
);

  localparam int OFFSET_BITS = $clog2(LINE_SIZE / 8);
  localparam int INDEX_BITS  = $clog2(DEPTH_LINES);
  localparam logic [3:0] COUNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    READY
  } state_t;

  state_t                  state_q, state_d;
  logic [3:0]              count_q, count_d;
  logic                    op_q, op_d;
  logic [INDEX_BITS-1:0]   index_q, index_d;
  logic [LINE_SIZE-1:0]    wdata_q, wdata_d;
  logic [LINE_SIZE-1:0]    data_out_q, data_out_d;
  logic                    access;
  logic [LINE_SIZE-1:0]    rd_line;

  // Contents start at zero and are never cleared by reset.
  logic [LINE_SIZE-1:0]    mem [DEPTH_LINES] = '{default: '0};

  // Byte-offset bits and bits above the index play no part in addressing.
  logic                    unused_address;
  assign unused_address = ^address;

  assign rd_line    = mem[index_q];
  assign data_out   = data_out_q;
  assign data_ready = (state_q == READY);
  assign in_use     = (state_q != IDLE);

  // Next-state logic: accept in IDLE, count down in BUSY, wait for op_done in READY.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    op_d       = op_q;
    index_d    = index_q;
    wdata_d    = wdata_q;
    data_out_d = data_out_q;
    access     = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) begin
          op_d    = op;
          index_d = address[OFFSET_BITS +: INDEX_BITS];
          wdata_d = data_in;
          count_d = COUNT_LOAD;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (count_q == 4'd0) begin
          access  = 1'b1;
          state_d = READY;
          if (!op_q) begin
            data_out_d = rd_line;
          end
        end else begin
          count_d = count_q - 4'd1;
        end
      end
      READY: begin
        if (op_done) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control and request registers; reset aborts any request in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      count_q    <= 4'd0;
      op_q       <= 1'b0;
      index_q    <= '0;
      wdata_q    <= '0;
      data_out_q <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      op_q       <= op_d;
      index_q    <= index_d;
      wdata_q    <= wdata_d;
      data_out_q <= data_out_d;
    end
  end

  // Storage array: the captured line is written on the cycle the write completes.
  always_ff @(posedge clk) begin
    if (access && op_q) begin
      mem[index_q] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_line_memory.sv
// Self-checking bench for line_memory: a vector table of line reads and
// writes, plus hand-written sequences for hold, reset abort and back-to-back.
module tb_line_memory;

  localparam int AW  = 32;
  localparam int LS  = 128;
  localparam int DL  = 4096;
  localparam int LAT = 5;

  localparam logic [LS-1:0] D1 = 128'h0011223344556677_8899AABBCCDDEEFF;
  localparam logic [LS-1:0] D2 = 128'hDEADBEEF01234567_89ABCDEFFEDCBA98;
  localparam logic [LS-1:0] D3 = 128'hA5A5A5A55A5A5A5A_0F0F0F0FF0F0F0F0;
  localparam logic [LS-1:0] D4 = 128'h13579BDF2468ACE0_11111111EEEEEEEE;
  localparam logic [LS-1:0] D5 = 128'hCAFEF00D12345678_9ABCDEF087654321;
  localparam logic [LS-1:0] DX = 128'hFFFFFFFFFFFFFFFF_FFFFFFFFFFFFFFFF;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          op;
  logic [AW-1:0] address;
  logic [LS-1:0] data_in;
  logic          op_done;
  logic [LS-1:0] data_out;
  logic          data_ready;
  logic          in_use;

  int n_checks = 0;
  int n_fails  = 0;

  logic [LS-1:0] scoreboard[$];
  logic [LS-1:0] last_read = '0;

  typedef struct {
    logic          op;
    logic [AW-1:0] addr;
    logic [LS-1:0] data;
    logic [LS-1:0] expected;
  } vec_t;

  vec_t vectors [10];

  line_memory #(
    .ADDRESS_WIDTH(AW),
    .LINE_SIZE(LS),
    .DEPTH_LINES(DL),
    .LATENCY(LAT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .op(op),
    .address(address),
    .data_in(data_in),
    .op_done(op_done),
    .data_out(data_out),
    .data_ready(data_ready),
    .in_use(in_use)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  task automatic checkBit(input string name, input logic actual, input logic expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s: got %b expected %b", name, actual, expected);
    end
  endtask

  task automatic checkLine(input string name, input logic [LS-1:0] actual, input logic [LS-1:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Presents a request just after a negedge and pushes the expected data_out.
  // wait_edges=2 means the DUT is still in READY with op_done raised alongside.
  task automatic applyStimulus(input logic req_op, input logic [AW-1:0] req_addr,
                               input logic [LS-1:0] req_data, input logic [LS-1:0] expected,
                               input int wait_edges);
    if (req_op) begin
      scoreboard.push_back(last_read);
    end else begin
      scoreboard.push_back(expected);
      last_read = expected;
    end
    enable  = 1'b1;
    op      = req_op;
    address = req_addr;
    data_in = req_data;
    if (wait_edges == 2) begin
      @(posedge clk);
      @(negedge clk);
      op_done = 1'b0;
      checkBit("b2b released in_use", in_use, 1'b0);
      checkBit("b2b released data_ready", data_ready, 1'b0);
    end
    @(posedge clk);
    @(negedge clk);
    enable  = 1'b0;
    op      = ~req_op;
    address = $urandom;
    data_in = {$urandom, $urandom, $urandom, $urandom};
    checkBit("accept in_use", in_use, 1'b1);
    checkBit("accept data_ready", data_ready, 1'b0);
  endtask

  // Counts cycles to data_ready, pulsing op_done once while busy (must be ignored).
  task automatic waitReady(input string name);
    int cnt = 0;
    while (data_ready !== 1'b1 && cnt < 20) begin
      op_done = (cnt == 1);
      @(negedge clk);
      cnt++;
    end
    op_done = 1'b0;
    n_checks++;
    if (cnt != LAT) begin
      n_fails++;
      $display("[TB] FAIL %s latency: got %0d cycles expected %0d", name, cnt, LAT);
    end
    checkBit({name, " in_use"}, in_use, 1'b1);
  endtask

  task automatic checkOutput(input string name);
    logic [LS-1:0] exp_line;
    n_checks++;
    if (scoreboard.size() == 0) begin
      n_fails++;
      $display("[TB] FAIL %s: got empty scoreboard expected an entry", name);
    end else begin
      exp_line = scoreboard.pop_front();
      checkBit({name, " data_ready"}, data_ready, 1'b1);
      checkLine({name, " data_out"}, data_out, exp_line);
    end
  endtask

  task automatic releaseOp(input string name);
    op_done = 1'b1;
    @(posedge clk);
    @(negedge clk);
    op_done = 1'b0;
    checkBit({name, " release data_ready"}, data_ready, 1'b0);
    checkBit({name, " release in_use"}, in_use, 1'b0);
  endtask

  // Watchdog in case the clocking itself stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vectors[0] = '{1'b1, 32'h0000_0040, D1, '0};
    vectors[1] = '{1'b0, 32'h0000_004C, '0, D1};
    vectors[2] = '{1'b0, 32'h0001_0040, '0, D1};
    vectors[3] = '{1'b1, 32'h0000_1230, D2, '0};
    vectors[4] = '{1'b0, 32'h0001_123F, '0, D2};
    vectors[5] = '{1'b0, 32'h0000_0050, '0, '0};
    vectors[6] = '{1'b1, 32'h0000_0040, D3, '0};
    vectors[7] = '{1'b0, 32'h0002_0040, '0, D3};
    vectors[8] = '{1'b1, 32'hFFFF_FFF0, D4, '0};
    vectors[9] = '{1'b0, 32'h0000_FFF5, '0, D4};

    reset   = 1'b1;
    enable  = 1'b0;
    op      = 1'b0;
    op_done = 1'b0;
    address = '0;
    data_in = '0;
    repeat (2) @(negedge clk);
    checkBit("reset data_ready", data_ready, 1'b0);
    checkBit("reset in_use", in_use, 1'b0);
    checkLine("reset data_out", data_out, '0);
    enable = 1'b1;
    @(negedge clk);
    checkBit("reset ignores enable", in_use, 1'b0);
    enable = 1'b0;
    reset  = 1'b0;

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vectors[i].op, vectors[i].addr, vectors[i].data, vectors[i].expected, 1);
      waitReady($sformatf("vec%0d", i));
      checkOutput($sformatf("vec%0d", i));
      releaseOp($sformatf("vec%0d", i));
    end

    applyStimulus(1'b0, 32'h0000_0048, '0, D3, 1);
    waitReady("hold");
    checkOutput("hold");
    for (int i = 0; i < 10; i++) begin
      enable  = ~enable;
      op      = 1'($urandom);
      address = $urandom;
      data_in = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      checkBit("hold data_ready", data_ready, 1'b1);
      checkBit("hold in_use", in_use, 1'b1);
      checkLine("hold data_out", data_out, last_read);
    end
    enable = 1'b0;
    releaseOp("hold");
    @(negedge clk);
    checkBit("hold no phantom request", in_use, 1'b0);

    applyStimulus(1'b1, 32'h0000_0080, DX, '0, 1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkBit("abort data_ready", data_ready, 1'b0);
    checkBit("abort in_use", in_use, 1'b0);
    checkLine("abort data_out", data_out, '0);
    void'(scoreboard.pop_front());
    last_read = '0;
    repeat (2) @(negedge clk);
    checkBit("abort held in_use", in_use, 1'b0);
    reset = 1'b0;
    applyStimulus(1'b0, 32'h0000_0080, '0, '0, 1);
    waitReady("after abort");
    checkOutput("after abort");
    releaseOp("after abort");

    applyStimulus(1'b1, 32'h0000_0090, D5, '0, 1);
    waitReady("b2b write");
    checkOutput("b2b write");
    op_done = 1'b1;
    applyStimulus(1'b0, 32'h0000_0094, '0, D5, 2);
    waitReady("b2b read");
    checkOutput("b2b read");
    releaseOp("b2b read");

    checkBit("scoreboard drained", scoreboard.size() == 0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/line_memory.md
LINE_MEMORY -- requirements
Module: line_memory

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 32, byte-address width.
REQ-002 Parameter LINE_SIZE, default 128, line width in bits (16 bytes).
REQ-003 Parameter DEPTH_LINES, default 4096, number of stored lines (power of two).
REQ-004 Parameter LATENCY, default 5, cycles from request acceptance to data_ready; legal range 1..15.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 reset  input  1  reset, asynchronous, active-high.
REQ-007 enable  input  1  request valid from the cache.
REQ-008 op  input  1  0 = read line, 1 = write line.
REQ-009 address  input  ADDRESS_WIDTH  byte address of the line.
REQ-010 data_in  input  LINE_SIZE  line to be written.
REQ-011 op_done  input  1  cache has consumed the result; releases the memory.
REQ-012 data_out  output  LINE_SIZE  line read; valid while data_ready=1 after a read.
REQ-013 data_ready  output  1  requested operation complete.
REQ-014 in_use  output  1  memory owned by an outstanding request.

Function
REQ-015 Storage SHALL be DEPTH_LINES x LINE_SIZE; line index = address[log2(LINE_SIZE/8) +: log2(DEPTH_LINES)].
REQ-016 Address byte-offset bits SHALL be ignored; accesses are always line-aligned.
REQ-017 Address bits above the index SHALL be ignored; addresses alias modulo DEPTH_LINES lines.
REQ-018 FSM SHALL have states IDLE, BUSY, READY.
REQ-019 In IDLE with enable=1, next edge SHALL latch op, index and data_in, load the counter with LATENCY-1, set in_use=1, and go to BUSY.
REQ-020 Request inputs SHALL be sampled only at acceptance; later changes have no effect on the operation.
REQ-021 In BUSY, the counter SHALL decrement each cycle; on the edge where it is 0, the access SHALL be performed and state goes to READY with data_ready=1.
REQ-022 Latency: request accepted at edge N -> data_ready=1 after edge N+LATENCY.
REQ-023 Write: latched data_in SHALL be stored at the READY-transition edge; data_out unchanged.
REQ-024 Read: data_out SHALL be loaded with the stored line at the READY-transition edge and held until the next read completes.
REQ-025 In READY, data_ready and in_use SHALL stay 1 until op_done=1 is sampled; that edge clears both and returns to IDLE.
REQ-026 enable sampled in BUSY or READY, and in the same cycle as op_done, SHALL be ignored; earliest new acceptance is the edge after return to IDLE.
REQ-027 op_done outside READY SHALL be ignored.
REQ-028 A read following a write to the same index SHALL return the written line.
REQ-029 Counter width SHALL be 4 bits; no wrap occurs within legal LATENCY.

Reset
REQ-030 reset=1 SHALL immediately force state IDLE, counter 0, data_ready=0, in_use=0, data_out=0.
REQ-031 Reset mid-operation SHALL abort it; a pending write SHALL NOT update storage.
REQ-032 Storage contents SHALL NOT be cleared by reset; initialised to all zeros at time zero only.
REQ-033 First acceptance after reset deassertion SHALL occur at the first rising edge with reset=0 and enable=1.

Verification
REQ-034 Write 0x00112233_44556677_8899AABB_CCDDEEFF to address 0x40, op_done on ready -> data_ready after exactly 5 cycles, in_use high throughout, low after op_done.
REQ-035 Read 0x4C after that write -> data_out = 0x00112233_44556677_8899AABB_CCDDEEFF after 5 cycles; offset ignored.
REQ-036 Read 0x10040 (aliases index 4 at depth 4096) -> returns line written at 0x40.
REQ-037 Hold op_done=0 for 10 cycles in READY while toggling enable -> data_ready and data_out stable, no new request accepted.
REQ-038 Assert reset 2 cycles into a write to 0x80, then read 0x80 -> zeros returned; outputs 0 during reset.
REQ-039 Back-to-back: op_done and enable together -> second request accepted one cycle later; data_ready after further 5 cycles.
